oflow_reg_file_apb_arbiter: RTL and testbench

Two-requester APB master that shares the single APB slave port of the oflow configuration register file between the host interface (requester 0) and the on-chip core controller (requester 1). It accepts simple valid/done register requests, arbitrates round-robin, and drives the APB setup/access phases. For reads it captures the slave's registered read data one cycle after the access phase. An optional timeout aborts accesses to unmapped addresses, which the register file never acknowledges.

---
 rtl/oflow_apb_arb_pkg.sv | 14 +
 rtl/oflow_reg_file_apb_arbiter_if.sv | 49 ++++
 rtl/oflow_reg_file_define.sv | 11 +
 rtl/oflow_rr_arb2.sv | 23 ++
 rtl/oflow_reg_file_apb_arbiter.sv | 148 ++++++++++++++
 tb/tb_oflow_reg_file_apb_arbiter.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/oflow_apb_arb_pkg.sv
// Shared types and constants for the oflow register-file APB arbiter.
package oflow_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RDCAP
    } arb_state_t;

    localparam int NUM_REQ                = 2;
    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/oflow_reg_file_apb_arbiter_if.sv
// Requester handshakes and APB master signals of the register-file arbiter.
`include "oflow_reg_file_define.sv"

interface oflow_reg_file_apb_arbiter_if;

    logic                 req0_valid;
    logic                 req0_write;
    logic [`ADDR_LEN-1:0] req0_addr;
    logic [31:0]          req0_wdata;
    logic                 req0_done;
    logic [31:0]          req0_rdata;
    logic                 req0_err;

    logic                 req1_valid;
    logic                 req1_write;
    logic [`ADDR_LEN-1:0] req1_addr;
    logic [31:0]          req1_wdata;
    logic                 req1_done;
    logic [31:0]          req1_rdata;
    logic                 req1_err;

    logic                 apb_psel;
    logic                 apb_penable;
    logic                 apb_pwrite;
    logic [`ADDR_LEN-1:0] apb_addr;
    logic [31:0]          apb_pwdata;
    logic                 apb_pready;
    logic [31:0]          apb_prdata;

    // master: the arbiter; slave: requesters plus the register file
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_done, req0_rdata, req0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_done, req1_rdata, req1_err,
        output apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata,
        input  apb_pready, apb_prdata
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_done, req0_rdata, req0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_done, req1_rdata, req1_err,
        input  apb_psel, apb_penable, apb_pwrite, apb_addr, apb_pwdata,
        output apb_pready, apb_prdata
    );

endinterface

// File: rtl/oflow_reg_file_define.sv
// Address width and register map of the oflow configuration register file.
`ifndef OFLOW_REG_FILE_DEFINE_SV
`define OFLOW_REG_FILE_DEFINE_SV

`define ADDR_LEN       10
`define W_IOU_ADDR     10'h000
`define W_WIDTH_ADDR   10'h001
`define W_HEIGHT_ADDR  10'h002
`define W_COLOR1_ADDR  10'h003

`endif

// File: rtl/oflow_rr_arb2.sv
// Combinational two-way round-robin picker; the requester not granted last wins a tie.
module oflow_rr_arb2
    import oflow_apb_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic               any
);

    logic [NUM_REQ-1:0] elig;

    always_comb begin
        elig  = req & ~mask;
        grant = elig;
        if (elig == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end
        any = |elig;
    end

endmodule

// File: rtl/oflow_reg_file_apb_arbiter.sv
// Two-requester round-robin APB master for the oflow register file.
// Optional ACCESS-phase timeout enabled by defining OFLOW_APB_ARB_TIMEOUT_EN.
//   state  | meaning
//   IDLE   | no transfer; done pulses here; next winner picked
//   SETUP  | APB setup phase (psel=1, penable=0)
//   ACCESS | APB access phase, waiting for pready
//   RDCAP  | read accepted; capture the registered prdata
`include "oflow_reg_file_define.sv"

module oflow_reg_file_apb_arbiter
    import oflow_apb_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                         clk,
    input  logic                         reset,
    oflow_reg_file_apb_arbiter_if.master bus
);

    arb_state_t                state, state_nxt;
    logic [NUM_REQ-1:0]        req, grant, done_q;
    logic [NUM_REQ-1:0][31:0]  rdata_q;
    logic                      any_req, last_grant, win_q;
    logic                      psel_q, penable_q, pwrite_q;
    logic [`ADDR_LEN-1:0]      addr_q;
    logic [31:0]               pwdata_q;
    logic                      start, wr_done, rd_done, abort, timed_out;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    assign req = {bus.req1_valid, bus.req0_valid};

    // a requester finishing this cycle is still holding valid; keep it out
    oflow_rr_arb2 u_rr_arb2 (
        .req        (req),
        .mask       (done_q),
        .last_grant (last_grant),
        .grant      (grant),
        .any        (any_req)
    );

`ifdef OFLOW_APB_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]   cnt;
    logic [NUM_REQ-1:0] err_q;

    assign timed_out = (cnt == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= '0;
        end else begin
            cnt   <= (state == ACCESS) ? cnt + 1'b1 : '0;
            err_q <= '0;
            if (abort) err_q[win_q] <= 1'b1;
        end
    end

    assign bus.req0_err = err_q[0];
    assign bus.req1_err = err_q[1];
`else
    assign timed_out    = 1'b0;
    assign bus.req0_err = 1'b0;
    assign bus.req1_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        wr_done   = 1'b0;
        rd_done   = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = SETUP;
                    start     = 1'b1;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (bus.apb_pready) begin
                    if (pwrite_q) begin
                        state_nxt = IDLE;
                        wr_done   = 1'b1;
                    end else begin
                        state_nxt = RDCAP;
                    end
                end else if (timed_out) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            RDCAP: begin
                state_nxt = IDLE;
                rd_done   = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            pwrite_q   <= 1'b0;
            addr_q     <= '0;
            pwdata_q   <= '0;
            last_grant <= 1'b1;
            win_q      <= 1'b0;
            done_q     <= '0;
            rdata_q    <= '0;
        end else begin
            state     <= state_nxt;
            psel_q    <= (state_nxt == SETUP) || (state_nxt == ACCESS);
            penable_q <= (state_nxt == ACCESS);
            done_q    <= '0;
            if (start) begin
                // grant is one-hot here, so AND-OR acts as the request mux
                win_q      <= grant[1];
                last_grant <= grant[1];
                pwrite_q   <= (grant[0] & bus.req0_write) | (grant[1] & bus.req1_write);
                addr_q     <= ({`ADDR_LEN{grant[0]}} & bus.req0_addr)
                            | ({`ADDR_LEN{grant[1]}} & bus.req1_addr);
                pwdata_q   <= ({32{grant[0]}} & bus.req0_wdata)
                            | ({32{grant[1]}} & bus.req1_wdata);
            end
            if (wr_done || rd_done || abort) done_q[win_q] <= 1'b1;
            if (rd_done) rdata_q[win_q] <= bus.apb_prdata;
            if (abort)   rdata_q[win_q] <= '0;
        end
    end

    assign bus.apb_psel    = psel_q;
    assign bus.apb_penable = penable_q;
    assign bus.apb_pwrite  = pwrite_q;
    assign bus.apb_addr    = addr_q;
    assign bus.apb_pwdata  = pwdata_q;
    assign bus.req0_done   = done_q[0];
    assign bus.req1_done   = done_q[1];
    assign bus.req0_rdata  = rdata_q[0];
    assign bus.req1_rdata  = rdata_q[1];

endmodule

// File: tb/tb_oflow_reg_file_apb_arbiter.sv
// Directed bench for the register-file APB arbiter with a zero-wait register file model.
`include "oflow_reg_file_define.sv"

module tb_oflow_reg_file_apb_arbiter;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    oflow_reg_file_apb_arbiter_if bus ();

    oflow_reg_file_apb_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // register file: four mapped registers, others never acknowledged
    logic [31:0] regs [4] = '{default: 32'h0};
    logic [31:0] prdata_q = 32'h0;
    logic        mapped;

    assign mapped         = (bus.apb_addr < `ADDR_LEN'(4));
    assign bus.apb_pready = bus.apb_psel & bus.apb_penable & mapped;
    assign bus.apb_prdata = prdata_q;

    always @(posedge clk) begin
        if (bus.apb_pready) begin
            if (bus.apb_pwrite) regs[bus.apb_addr[1:0]] <= bus.apb_pwdata;
            else                prdata_q <= regs[bus.apb_addr[1:0]];
        end
    end

    function automatic logic [31:0] reg_val(input logic [`ADDR_LEN-1:0] a);
        return regs[a[1:0]];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic v, input logic wr,
                           input logic [`ADDR_LEN-1:0] a, input logic [31:0] d);
        if (r == 0) begin
            bus.req0_valid = v; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    // issues a request in the current cycle (cycle 0); lat is the done cycle, -1 if none
    task automatic do_req(input int r, input logic wr, input logic [`ADDR_LEN-1:0] a,
                          input logic [31:0] d, input int budget,
                          output int lat, output logic [31:0] rd, output logic er);
        lat = -1;
        rd  = 'x;
        er  = 1'bx;
        set_req(r, 1'b1, wr, a, d);
        for (int c = 1; c <= budget; c++) begin
            step();
            if ((r == 0) ? bus.req0_done : bus.req1_done) begin
                lat = c;
                rd  = (r == 0) ? bus.req0_rdata : bus.req1_rdata;
                er  = (r == 0) ? bus.req0_err : bus.req1_err;
                break;
            end
        end
        step();
        set_req(r, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        er;
        int          n0, n1, dcnt;
        logic [15:0] d0v, d1v, pselv;
        logic [31:0] a4, a7;

        set_req(0, 1'b0, 1'b0, '0, '0);
        set_req(1, 1'b0, 1'b0, '0, '0);
        step();
        step();
        reset = 1'b0;
        step();

        chk("rst_psel",    32'(bus.apb_psel), 32'd0);
        chk("rst_penable", 32'(bus.apb_penable), 32'd0);
        chk("rst_addr",    32'(bus.apb_addr), 32'd0);
        chk("rst_done",    32'({bus.req1_done, bus.req0_done}), 32'd0);
        chk("rst_rdata0",  bus.req0_rdata, 32'd0);
        chk("rst_err",     32'({bus.req1_err, bus.req0_err}), 32'd0);

        // host write IOU = 5, cycle by cycle
        set_req(0, 1'b1, 1'b1, `W_IOU_ADDR, 32'h5);
        step();
        chk("wr_c1_psel_pen", 32'({bus.apb_psel, bus.apb_penable}), 32'b10);
        chk("wr_c1_addr",     32'(bus.apb_addr), 32'(`W_IOU_ADDR));
        chk("wr_c1_wdata",    bus.apb_pwdata, 32'h5);
        chk("wr_c1_pwrite",   32'(bus.apb_pwrite), 32'd1);
        step();
        chk("wr_c2_psel_pen", 32'({bus.apb_psel, bus.apb_penable}), 32'b11);
        step();
        chk("wr_c3_done_err", 32'({bus.req0_done, bus.req0_err}), 32'b10);
        chk("wr_c3_psel",     32'(bus.apb_psel), 32'd0);
        chk("wr_iou_reg",     reg_val(`W_IOU_ADDR), 32'h5);
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        chk("wr_c4_done",     32'(bus.req0_done), 32'd0);

        // host writes WIDTH, core reads it back
        do_req(0, 1'b1, `W_WIDTH_ADDR, 32'h7, 20, lat, rd, er);
        chk("width_wr_lat", 32'(lat), 32'd3);
        do_req(1, 1'b0, `W_WIDTH_ADDR, 32'h0, 20, lat, rd, er);
        chk("core_rd_lat",   32'(lat), 32'd4);
        chk("core_rd_rdata", rd, 32'h7);
        chk("core_rd_err",   32'(er), 32'd0);
        do_req(0, 1'b0, `W_IOU_ADDR, 32'h0, 20, lat, rd, er);
        chk("iou_rd_lat",    32'(lat), 32'd4);
        chk("iou_rd_rdata",  rd, 32'h5);
        chk("nonwin_rdata1", bus.req1_rdata, 32'h7);
        do_req(0, 1'b1, `W_IOU_ADDR, 32'h5, 20, lat, rd, er);
        chk("wr_keeps_rdata0", bus.req0_rdata, 32'h5);

        // both valid from reset: expected grant order 0,1,0,1
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        set_req(0, 1'b1, 1'b1, `W_HEIGHT_ADDR, 32'h11);
        set_req(1, 1'b1, 1'b1, `W_COLOR1_ADDR, 32'h22);
        n0 = 0; n1 = 0;
        d0v = '0; d1v = '0; pselv = '0;
        a4 = '0; a7 = '0;
        pselv[0] = bus.apb_psel;
        for (int c = 1; c <= 13; c++) begin
            step();
            if (d0v[c-1]) begin
                n0++;
                if (n0 < 2) set_req(0, 1'b1, 1'b1, `W_HEIGHT_ADDR, 32'h33);
                else        set_req(0, 1'b0, 1'b0, '0, '0);
            end
            if (d1v[c-1]) begin
                n1++;
                if (n1 < 2) set_req(1, 1'b1, 1'b1, `W_COLOR1_ADDR, 32'h44);
                else        set_req(1, 1'b0, 1'b0, '0, '0);
            end
            d0v[c]   = bus.req0_done;
            d1v[c]   = bus.req1_done;
            pselv[c] = bus.apb_psel;
            if (c == 4) a4 = 32'(bus.apb_addr);
            if (c == 7) a7 = 32'(bus.apb_addr);
        end
        chk("rr_done0_cycles", 32'(d0v), 32'h0208);
        chk("rr_done1_cycles", 32'(d1v), 32'h1040);
        chk("rr_psel_cycles",  32'(pselv), 32'h0DB6);
        chk("rr_addr_c4",      a4, 32'(`W_COLOR1_ADDR));
        chk("rr_addr_c7",      a7, 32'(`W_HEIGHT_ADDR));
        chk("rr_height_reg",   reg_val(`W_HEIGHT_ADDR), 32'h33);
        chk("rr_color1_reg",   reg_val(`W_COLOR1_ADDR), 32'h44);

        do_req(0, 1'b0, `W_IOU_ADDR, 32'h0, 20, lat, rd, er);
        chk("pre_to_rdata", rd, 32'h5);

        // unmapped read
`ifdef OFLOW_APB_ARB_TIMEOUT_EN
        do_req(0, 1'b0, 10'h3FF, 32'h0, 40, lat, rd, er);
        chk("to_lat",   32'(lat), 32'd19);
        chk("to_err",   32'(er), 32'd1);
        chk("to_rdata", rd, 32'h0);
`else
        set_req(0, 1'b1, 1'b0, 10'h3FF, 32'h0);
        dcnt = 0;
        for (int c = 1; c <= 102; c++) begin
            step();
            if (bus.req0_done) dcnt++;
        end
        chk("hang_no_done",  32'(dcnt), 32'd0);
        chk("hang_psel_pen", 32'({bus.apb_psel, bus.apb_penable}), 32'b11);
        reset = 1'b1;
        step();
        set_req(0, 1'b0, 1'b0, '0, '0);
        reset = 1'b0;
        step();
`endif

        // reset during the ACCESS phase of a write
        set_req(0, 1'b1, 1'b1, `W_IOU_ADDR, 32'hAA);
        step();
        step();
        chk("mid_rst_access", 32'({bus.apb_psel, bus.apb_penable}), 32'b11);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", 32'({bus.apb_psel, bus.apb_penable, bus.req0_done}), 32'b000);
        set_req(0, 1'b0, 1'b0, '0, '0);
        step();
        reset = 1'b0;
        step();
        step();
        chk("mid_rst_no_done", 32'(bus.req0_done), 32'd0);
        chk("mid_rst_reg",     reg_val(`W_IOU_ADDR), 32'h5);
        do_req(0, 1'b0, `W_IOU_ADDR, 32'h0, 20, lat, rd, er);
        chk("post_rst_lat",   32'(lat), 32'd4);
        chk("post_rst_rdata", rd, 32'h5);
        do_req(1, 1'b1, `W_WIDTH_ADDR, 32'h9, 20, lat, rd, er);
        chk("post_rst_wr_lat", 32'(lat), 32'd3);
        chk("post_rst_width",  reg_val(`W_WIDTH_ADDR), 32'h9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
